// File: rtl/epochtv1_pkg.sv
// Shared types for the Epoch TV-1 sprite line-buffer fill engine:
// OAM attribute layout, fill FSM states and line constants.
package epochtv1_pkg;

    localparam int NUM_OBJ  = 128;
    localparam int MAX_HITS = 16;

    typedef struct packed {
        logic       split;
        logic [6:0] pat;
        logic [6:0] x;
        logic       link_x;
        logic       start_line;
        logic [2:0] rsvd;
        logic [3:0] color;
        logic [6:0] y;
        logic       link_y;
    } s_objattr;

    typedef enum logic [2:0] {
        ST_CLR,
        ST_IDLE,
        ST_SCAN,
        ST_FETCH0,
        ST_FETCH1,
        ST_DRAW
    } state_t;

endpackage

// File: rtl/epochtv1_olb_ram.sv
// Ping-pong object line buffer, 2x256x5. Port A writes (fill or init-clear);
// port B is a read-and-clear port with a registered 1-CLK read result.
module epochtv1_olb_ram (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_a_we,
    input  logic [8:0] i_a_addr,
    input  logic [4:0] i_a_data,
    input  logic       i_b_re,
    input  logic [8:0] i_b_addr,
    output logic [4:0] o_b_q
);

    logic [4:0] r_mem [512];
    logic [4:0] r_q;

    // Port B clears the entry it reads so a buffer is empty when it is next filled.
    always_ff @(posedge i_clk) begin
        if (i_a_we) r_mem[i_a_addr] <= i_a_data;
        if (i_b_re) r_mem[i_b_addr] <= '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_q <= '0;
        else if (i_b_re) r_q <= r_mem[i_b_addr];
    end

    assign o_b_q = r_q;

endmodule

// File: rtl/epochtv1_spr_fill.sv
// Sprite line-buffer fill engine: scans OAM for the next scanline, fetches two
// pattern words per hit and draws 16 pixels into the fill half of the OLB.
module epochtv1_spr_fill
    import epochtv1_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_start,
    input  logic [8:0]  i_row,
    output logic [6:0]  o_oam_a,
    input  logic [31:0] i_oam_d,
    output logic [10:0] o_vram_a,
    input  logic [15:0] i_vram_d,
    input  logic        i_rd_en,
    input  logic [7:0]  i_rd_x,
    output logic [4:0]  o_rd_px,
    output logic        o_busy,
    output logic        o_ovf,
    output state_t      o_dbg_state
);

    state_t      r_state;
    logic [8:0]  r_clr_cnt;
    logic        r_sel;
    logic [1:0]  r_valid;
    logic        r_done;
    logic        r_busy;
    logic        r_ovf;
    logic        r_ovf_pend;
    logic [4:0]  r_hits;
    logic [8:0]  r_row;
    logic [7:0]  r_nxt;
    logic        r_chk_v;
    logic [6:0]  r_x;
    logic [3:0]  r_color;
    logic        r_spr_y0;
    logic [15:0] r_w0;
    logic [15:0] r_w1;
    logic [3:0]  r_j;
    logic [10:0] r_vram_a;
    logic        r_rd_ok;

    s_objattr    w_oa;
    logic [8:0]  w_y0;
    logic        w_hit;
    logic [3:0]  w_spr_y;
    logic [3:0]  w_k;
    logic [15:0] w_word;
    logic        w_px;
    logic [7:0]  w_draw_x;
    logic        w_a_we;
    logic [8:0]  w_a_addr;
    logic [4:0]  w_a_data;
    logic [4:0]  w_b_q;
    logic        w_unused_oa;

    assign w_oa        = s_objattr'(i_oam_d);
    assign w_unused_oa = ^{w_oa.split, w_oa.link_x, w_oa.start_line, w_oa.rsvd, w_oa.link_y};
    assign w_y0        = {1'b0, w_oa.y, 1'b0};
    assign w_hit       = r_chk_v && (r_row >= w_y0) && (r_row <= w_y0 + 9'd15);
    assign w_spr_y     = r_row[3:0] - w_y0[3:0];

    // Pattern bit order: left nibble of each 8-pixel half comes from the low byte.
    assign w_k      = {~r_j[2], r_spr_y0, r_j[1:0]};
    assign w_word   = r_j[3] ? r_w1 : r_w0;
    assign w_px     = w_word[4'd15 - w_k];
    assign w_draw_x = {r_x, 1'b0} + {4'b0000, r_j};

    assign w_a_we   = (r_state == ST_CLR) || ((r_state == ST_DRAW) && w_px);
    assign w_a_addr = (r_state == ST_CLR) ? r_clr_cnt : {r_sel, w_draw_x};
    assign w_a_data = (r_state == ST_CLR) ? 5'd0 : {1'b1, r_color};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_CLR;
            r_clr_cnt  <= '0;
            r_sel      <= 1'b0;
            r_valid    <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_ovf      <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_hits     <= '0;
            r_row      <= '0;
            r_nxt      <= '0;
            r_chk_v    <= 1'b0;
            r_x        <= '0;
            r_color    <= '0;
            r_spr_y0   <= 1'b0;
            r_w0       <= '0;
            r_w1       <= '0;
            r_j        <= '0;
            r_vram_a   <= '0;
        end else begin
            case (r_state)
                ST_CLR: begin
                    r_clr_cnt <= r_clr_cnt + 9'd1;
                    if (r_clr_cnt == 9'd511) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: ;
                ST_SCAN: begin
                    // OAM_D lags OAM_A by one CLK; r_chk_v marks a word worth testing.
                    if (w_hit && (r_hits != 5'(MAX_HITS))) begin
                        r_x      <= w_oa.x;
                        r_color  <= w_oa.color;
                        r_spr_y0 <= w_spr_y[0];
                        r_hits   <= r_hits + 5'd1;
                        r_chk_v  <= 1'b0;
                        r_vram_a <= {w_oa.pat, w_spr_y[3:1], 1'b0};
                        r_state  <= ST_FETCH0;
                    end else begin
                        if (w_hit) r_ovf_pend <= 1'b1;
                        if (r_nxt[7]) begin
                            r_chk_v <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_chk_v <= 1'b1;
                            r_nxt   <= r_nxt + 8'd1;
                        end
                    end
                end
                ST_FETCH0: begin
                    r_vram_a[0] <= 1'b1;
                    r_state     <= ST_FETCH1;
                end
                ST_FETCH1: begin
                    r_w0    <= i_vram_d;
                    r_j     <= '0;
                    r_state <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (r_j == 4'd0) r_w1 <= i_vram_d;
                    r_j <= r_j + 4'd1;
                    if (r_j == 4'd15) r_state <= ST_SCAN;
                end
                default: r_state <= ST_CLR;
            endcase

            // A new line always wins: an unfinished fill is abandoned and marked invalid.
            if (i_start && (r_state != ST_CLR)) begin
                r_sel          <= ~r_sel;
                r_valid[r_sel] <= r_done;
                r_ovf          <= r_ovf_pend;
                r_ovf_pend     <= 1'b0;
                r_hits         <= '0;
                r_done         <= 1'b0;
                r_busy         <= 1'b1;
                r_row          <= i_row;
                r_nxt          <= '0;
                r_chk_v        <= 1'b0;
                r_state        <= ST_SCAN;
            end
        end
    end

    // Display read is accepted when CE & RD_EN; the result appears on the next CLK and holds otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                r_rd_ok <= 1'b0;
        else if (i_ce && i_rd_en) r_rd_ok <= r_valid[~r_sel];
    end

    epochtv1_olb_ram u_olb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_a_we   (w_a_we),
        .i_a_addr (w_a_addr),
        .i_a_data (w_a_data),
        .i_b_re   (i_ce && i_rd_en),
        .i_b_addr ({~r_sel, i_rd_x}),
        .o_b_q    (w_b_q)
    );

    assign o_oam_a     = r_nxt[6:0];
    assign o_vram_a    = r_vram_a;
    assign o_rd_px     = r_rd_ok ? w_b_q : 5'd0;
    assign o_busy      = r_busy;
    assign o_ovf       = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_epochtv1_spr_fill.sv
// Bench for epochtv1_spr_fill: OAM/VRAM models, a per-line reference renderer
// and a read scoreboard drained by a monitor on the falling clock edge.
module tb_epochtv1_spr_fill;
    import epochtv1_pkg::*;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        ce = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  row = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_x = '0;
    logic [6:0]  oam_a;
    logic [31:0] oam_d = '0;
    logic [10:0] vram_a;
    logic [15:0] vram_d = '0;
    logic [4:0]  rd_px;
    logic        busy;
    logic        ovf;
    state_t      dbg_state;

    logic [31:0] oam  [128];
    logic [15:0] vram [2048];

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [4:0]  exp_q[$];
    int          col_q[$];
    logic [4:0]  exp_line [256];
    logic        exp_ovf;
    logic        mon_pend = 1'b0;
    logic        mon_hold = 1'b0;
    logic [4:0]  last_exp = '0;

    epochtv1_spr_fill dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ce        (ce),
        .i_start     (start),
        .i_row       (row),
        .o_oam_a     (oam_a),
        .i_oam_d     (oam_d),
        .o_vram_a    (vram_a),
        .i_vram_d    (vram_d),
        .i_rd_en     (rd_en),
        .i_rd_x      (rd_x),
        .o_rd_px     (rd_px),
        .o_busy      (busy),
        .o_ovf       (ovf),
        .o_dbg_state (dbg_state)
    );

    // synchronous OAM / VRAM memories and read-event tracking
    always @(posedge clk) begin
        oam_d    <= oam[oam_a];
        vram_d   <= vram[vram_a];
        mon_pend <= ce && rd_en && !rst;
        mon_hold <= !ce && rd_en && !rst;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    task automatic monitor_loop();
        logic [4:0] e;
        int c;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_exp = '0;
            end else if (mon_pend) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rd_px_unexpected: got 0x%0h with no read queued", rd_px);
                end else begin
                    e = exp_q.pop_front();
                    c = col_q.pop_front();
                    check($sformatf("rd_px_col%0d", c), int'(rd_px), int'(e));
                    last_exp = e;
                end
            end else if (mon_hold) begin
                check("rd_px_hold", int'(rd_px), int'(last_exp));
            end
        end
    endtask

    function automatic logic [31:0] mk_oa(input int y, input int x, input int pat, input int color);
        s_objattr o;
        o       = '0;
        o.y     = 7'(y);
        o.x     = 7'(x);
        o.pat   = 7'(pat);
        o.color = 4'(color);
        return o;
    endfunction

    // reference renderer: what one scanline should look like
    task automatic model_line(input int r_line);
        s_objattr oa;
        int hits, y0, r, bit_i, addr;
        logic [15:0] wd;
        for (int c = 0; c < 256; c++) exp_line[c] = '0;
        exp_ovf = 1'b0;
        hits = 0;
        for (int i = 0; i < 128; i++) begin
            oa = s_objattr'(oam[i]);
            y0 = 2 * int'(oa.y);
            if (r_line >= y0 && r_line <= y0 + 15) begin
                if (hits == 16) begin
                    exp_ovf = 1'b1;
                end else begin
                    hits++;
                    r = r_line - y0;
                    for (int j = 0; j < 16; j++) begin
                        addr  = int'(oa.pat) * 16 + (r / 2) * 2 + j / 8;
                        wd    = vram[addr];
                        bit_i = 15 - (((j % 8) < 4) ? 8 : 0) - (r % 2) * 4 - (j % 4);
                        if (wd[bit_i]) exp_line[(2 * int'(oa.x) + j) % 256] = {1'b1, oa.color};
                    end
                end
            end
        end
    endtask

    // driver tasks (each leaves time 1 unit past a rising edge)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        int n;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", int'(busy), 1);
        check("rst_ovf", int'(ovf), 0);
        check("rst_rd_px", int'(rd_px), 0);
        check("rst_oam_a", int'(oam_a), 0);
        check("rst_vram_a", int'(vram_a), 0);
        check("rst_state", int'(dbg_state), int'(ST_CLR));
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        check("clr_cycles", n, 512);
    endtask

    task automatic do_start(input int r_line);
        start = 1'b1;
        row   = 9'(r_line);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 700) begin
            tick();
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic rd_one(input int c, input logic [4:0] e);
        ce    = 1'b1;
        rd_en = 1'b1;
        rd_x  = 8'(c);
        exp_q.push_back(e);
        col_q.push_back(c);
        tick();
        ce    = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic read_all(input logic line_valid);
        for (int c = 0; c < 256; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                ce    = 1'b0;
                rd_en = 1'b1;
                rd_x  = 8'($urandom);
                tick();
            end
            rd_one(c, line_valid ? exp_line[c] : 5'd0);
        end
        tick();
        tick();
    endtask

    task automatic frame(input int r_line);
        model_line(r_line);
        do_start(r_line);
        wait_idle("fill_done");
        do_start(511);
        check("ovf", int'(ovf), int'(exp_ovf));
        read_all(1'b1);
        wait_idle("dummy_fill_done");
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 128; i++) oam[i] = mk_oa(127, 0, 0, 0);
    endtask

    task automatic set_pat(input int p);
        for (int i = 0; i < 16; i++) vram[p * 16 + i] = 16'hFFFF;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2048; i++) vram[i] = 16'($urandom);
        clear_oam();
        fork
            monitor_loop();
        join_none

        // reset and init-clear; nothing valid to display yet
        do_reset();
        read_all(1'b0);

        // single sprite, full pattern
        clear_oam();
        oam[5] = mk_oa(10, 20, 2, 9);
        set_pat(2);
        frame(25);
        rd_one(40, 5'd0);
        tick();
        tick();

        // overlapping sprites: higher index wins
        clear_oam();
        oam[0] = mk_oa(10, 0, 1, 3);
        oam[1] = mk_oa(10, 0, 1, 7);
        set_pat(1);
        frame(20);

        // horizontal wrap
        clear_oam();
        oam[9] = mk_oa(40, 124, 3, 5);
        set_pat(3);
        frame(85);

        // 20 hits on one line: only the first 16 drawn
        clear_oam();
        for (int i = 0; i < 20; i++) oam[i * 3] = mk_oa(20, (i * 12) % 128, 10 + i, i % 16);
        frame(50);

        // random OAM and rows
        repeat (6) begin
            for (int i = 0; i < 128; i++) oam[i] = $urandom;
            frame($urandom_range(0, 300));
        end

        // every entry hits
        for (int i = 0; i < 128; i++)
            oam[i] = mk_oa(50 - $urandom_range(0, 7), $urandom_range(0, 127),
                           $urandom_range(0, 127), $urandom_range(0, 15));
        frame(100);

        // aborted fill displays transparent
        do_start(100);
        repeat (100) tick();
        do_start(511);
        read_all(1'b0);
        wait_idle("after_abort");

        // reset in the middle of drawing
        do_start(100);
        n = 0;
        while (dbg_state != ST_DRAW && n < 300) begin
            tick();
            n++;
        end
        check("reach_draw", int'(dbg_state == ST_DRAW), 1);
        rst = 1'b1;
        #2;
        check("async_rst_busy", int'(busy), 1);
        check("async_rst_state", int'(dbg_state), int'(ST_CLR));
        do_reset();
        read_all(1'b0);
        for (int i = 0; i < 128; i++) oam[i] = $urandom;
        frame($urandom_range(0, 250));

        tick();
        tick();
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
